fp_add_operand_seq: RTL and testbench
=====================================

Name: fp_add_operand_seq

Overview:
Sequencer directly upstream of fp_add, plus result capture downstream of it. It takes FP8 E5M2 operands one byte at a time over a valid/ready stream and holds A, B and the subtract bit stable on the adder inputs. After a fixed adder latency it samples the adder result and presents it on a valid/ready output stream. It serves as the byte-serial front end of the 8-bit-pin adder tile.

Parameters:
WIDTH, 8, operand/result width in bits; must match the fp_add WIDTH.
EXP_WIDTH, 5, exponent field width; used only by the optional flag logic.
MAN_WIDTH, 2, mantissa field width; used only by the optional flag logic.
ADD_LATENCY, 0, clock cycles between stable adder inputs and a valid add_result; legal range 0..7.

Ports:
clk  input  1  clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  operand byte
in_valid  input  1  in_data (and in_is_sub) valid
in_is_sub  input  1  operation select; sampled only with operand B (1 = A-B)
in_ready  output  1  sequencer can accept an operand this cycle
add_a  output  WIDTH  operand A to fp_add.a
add_b  output  WIDTH  operand B to fp_add.b
add_subtract  output  1  to fp_add.subtract
add_result  input  WIDTH  from fp_add.result
out_data  output  WIDTH  captured result
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_flag  output  1  special-value flag (see Optional Feature)

Behaviour:
- Reset state on the first edge with reset=1:
  - state=LOAD_A, add_a=0, add_b=0, add_subtract=0, out_data=0, out_valid=0, out_flag=0, wait counter=0.
  - in_ready=0 in any cycle where reset=1.
- Reset mid-operation abandons any partial operand, pending result or unaccepted output. No output handshake occurs for it.
- States: LOAD_A, LOAD_B, WAIT, DONE. Register outputs: out_valid, out_data, out_flag and the add_* signals.
- in_ready = 1 in LOAD_A and LOAD_B when reset=0, else 0. An input handshake is in_valid & in_ready at the rising edge.
- LOAD_A:
  - On handshake: add_a <= in_data, go to LOAD_B.
  - No handshake: hold.
  - in_is_sub is ignored.
- LOAD_B:
  - On handshake: add_b <= in_data, add_subtract <= in_is_sub, counter <= ADD_LATENCY, go to WAIT.
- WAIT:
  - counter != 0: decrement.
  - counter == 0: out_data <= add_result, out_valid <= 1, go to DONE.
  - Timing: with the B handshake at edge N, out_valid first reads 1 after edge N+1+ADD_LATENCY.
- DONE:
  - out_valid=1; out_data stable until out_ready=1 at an edge.
  - On output handshake: out_valid <= 0, go to LOAD_A.
  - in_ready=0 throughout, so there is no input/output overlap.
- add_a, add_b and add_subtract hold their last values after DONE until overwritten by the next handshake.
- in_valid with in_ready=0 is not consumed; upstream must hold its data.
- Counter width is 3 bits; no wrap, because it loads at most 7 and stops at 0.

Optional Feature:
Macro FP_SEQ_SPECIAL_FLAG_EN.
- Defined: out_flag is captured with out_data. It is 1 if the add_result exponent field is all ones (inf/NaN encoding), or if either captured operand exponent is all ones. It clears with out_valid.
- Undefined: out_flag is constant 0 and no flag logic is synthesized; the port still exists.

Test Plan:
1. ADD_LATENCY=0 with real fp_add: A=0x3C, B=0x3C, is_sub=0, out_ready=1 -> out_data=0x40 with out_valid high exactly 1 cycle after the B handshake edge; state returns to LOAD_A.
2. A=0x3C, B=0x3C, is_sub=1 -> out_data=0x00; add_subtract=1 while in WAIT.
3. ADD_LATENCY=3 with a 3-stage delayed stub adder (A=0x40, B=0x3C, add -> 0x42) -> out_valid rises 4 cycles after the B handshake; out_data=0x42, never an intermediate stub value.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data held, in_ready=0, and in_valid=1 bytes are not consumed; out_ready=1 -> one handshake, in_ready=1 next cycle.
5. Reset mid-operation: A=0x3C accepted, reset high 1 cycle -> all outputs 0; next bytes 0x40, 0x40 (add) treated as A then B -> out_data=0x44.
6. With FP_SEQ_SPECIAL_FLAG_EN: A=0x7C, B=0x3C -> out_flag=1 alongside out_valid. Without the macro, the same stimulus gives out_flag=0.

Source files
------------

// File: rtl/fp_add_operand_seq.sv
// fp_add_operand_seq: byte-serial operand sequencer and result capture around fp_add; FP_SEQ_SPECIAL_FLAG_EN enables out_flag
module fp_add_operand_seq #(
  parameter int WIDTH       = 8,
  parameter int EXP_WIDTH   = 5,
  parameter int MAN_WIDTH   = 2,
  parameter int ADD_LATENCY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_is_sub,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_subtract,
  input  logic [WIDTH-1:0] add_result,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_flag
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, WAIT, DONE} state_t;
  state_t           r_state, w_next;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_out;
  logic             r_sub, r_valid, r_flag;
  logic             w_hs_in, w_hs_out, w_flag;
  if ((1 + EXP_WIDTH + MAN_WIDTH) != WIDTH || ADD_LATENCY < 0 || ADD_LATENCY > 7) begin : g_bad_cfg
    $error("fp_add_operand_seq: inconsistent field widths or ADD_LATENCY outside 0..7");
  end
  assign in_ready     = !reset && (r_state == LOAD_A || r_state == LOAD_B);
  assign w_hs_in      = in_valid && in_ready;
  assign w_hs_out     = r_valid && out_ready;
  assign add_a        = r_a;
  assign add_b        = r_b;
  assign add_subtract = r_sub;
  assign out_data     = r_out;
  assign out_valid    = r_valid;
  assign out_flag     = r_flag;
`ifdef FP_SEQ_SPECIAL_FLAG_EN
  // exponent all ones on the result or either held operand marks inf/NaN
  assign w_flag = &add_result[MAN_WIDTH +: EXP_WIDTH] | &r_a[MAN_WIDTH +: EXP_WIDTH] | &r_b[MAN_WIDTH +: EXP_WIDTH];
`else
  assign w_flag = 1'b0;
`endif
  // next state: two operand loads, latency wait, then hold until the result is taken
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD_A:  w_next = w_hs_in ? LOAD_B : LOAD_A;
      LOAD_B:  w_next = w_hs_in ? WAIT : LOAD_B;
      WAIT:    w_next = (r_cnt == 3'd0) ? DONE : WAIT;
      DONE:    w_next = w_hs_out ? LOAD_A : DONE;
      default: w_next = LOAD_A;
    endcase
  end
  // state, operand holding registers, latency counter and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD_A;
      r_cnt   <= 3'd0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD_A && w_hs_in) r_a <= in_data;
      if (r_state == LOAD_B && w_hs_in) begin
        r_b   <= in_data;
        r_sub <= in_is_sub;
        r_cnt <= 3'(ADD_LATENCY);
      end
      if (r_state == WAIT && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
      if (r_state == WAIT && r_cnt == 3'd0) begin
        r_out   <= add_result;
        r_valid <= 1'b1;
        r_flag  <= w_flag;
      end
      if (w_hs_out) begin
        r_valid <= 1'b0;
        r_flag  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_add_operand_seq.sv
// tb_fp_add_operand_seq: random and directed scoreboard bench with a delayed stand-in adder
module tb_fp_add_operand_seq;
  localparam int LAT = 3;
  logic       clk = 1'b0;
  logic       reset, in_valid, in_is_sub, in_ready, add_subtract, out_valid, out_ready, out_flag;
  logic [7:0] in_data, add_a, add_b, add_result, out_data;
  int         total = 0, bad = 0, ecnt = 0, due = 0, ph = 0;
  logic       take = 1'b0, started = 1'b0, after_rst = 1'b0;
  logic [7:0] ma = 8'h00, mb = 8'h00;
  logic       ms = 1'b0;
  logic [8:0] q[$];

  fp_add_operand_seq #(.WIDTH(8), .EXP_WIDTH(5), .MAN_WIDTH(2), .ADD_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_is_sub(in_is_sub),
    .in_ready(in_ready), .add_a(add_a), .add_b(add_b), .add_subtract(add_subtract),
    .add_result(add_result), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_flag(out_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  // stand-in adder: plain byte arithmetic, so a stale or early sample shows up as a wrong value
  function automatic logic [7:0] stub(input logic [7:0] a, input logic [7:0] b, input logic s);
    return s ? a - b : a + b;
  endfunction

  function automatic logic ref_flag(input logic [7:0] r, input logic [7:0] a, input logic [7:0] b);
`ifdef FP_SEQ_SPECIAL_FLAG_EN
    return (r[6:2] == 5'h1f) || (a[6:2] == 5'h1f) || (b[6:2] == 5'h1f);
`else
    return 1'b0;
`endif
  endfunction

  if (LAT == 0) begin : g_comb
    assign add_result = stub(add_a, add_b, add_subtract);
  end else begin : g_pipe
    logic [7:0] p[LAT];
    always @(posedge clk) begin
      p[0] <= stub(add_a, add_b, add_subtract);
      for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
    end
    assign add_result = p[LAT-1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at edge %0d", nm, act, exp, ecnt);
    end
  endtask

  // reference model: evaluates the coming edge from operand count and elapsed cycles
  always @(negedge clk) begin : model
    logic ev;
    if (after_rst) started = 1'b1;
    ev = (ph == 2) && (ecnt >= due);
    if (started) begin
      chk("in_ready", in_ready, !reset && ph != 2);
      chk("out_valid", out_valid, ev);
      chk("add_a", add_a, ma);
      chk("add_b", add_b, mb);
      chk("add_subtract", add_subtract, ms);
      if (!ev) chk("out_flag_idle", out_flag, 0);
      if (after_rst) chk("out_data_reset", out_data, 0);
    end
    take = 1'b0;
    after_rst = reset;
    if (reset) begin
      ph = 0; ma = 8'h00; mb = 8'h00; ms = 1'b0;
      q.delete();
    end else if (ph == 0 && in_valid) begin
      ma = in_data; ph = 1; take = 1'b1;
    end else if (ph == 1 && in_valid) begin
      mb = in_data; ms = in_is_sub; ph = 2; take = 1'b1;
      due = ecnt + 2 + LAT;
      q.push_back({ref_flag(stub(ma, mb, ms), ma, mb), stub(ma, mb, ms)});
    end else if (ev && out_ready) ph = 0;
  end

  // monitor: compares every presented result against the scoreboard head, pops on handshake
  always @(negedge clk) begin
    if (started && !reset && out_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL out_unexpected actual=%0h expected=none", out_data);
      end else begin
        chk("out_data", out_data, q[0][7:0]);
        chk("out_flag", out_flag, q[0][8]);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic s);
    bit ok = 0;
    in_data = d; in_is_sub = s; in_valid = 1'b1;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(posedge clk);
      ok = take;
    end
    if (!ok) begin total++; bad++; $display("FAIL send_timeout actual=0 expected=1 data=%0h", d); end
    #1 in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_is_sub = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    cycles(3);
    reset = 1'b0;
    send(8'h3c, 0); send(8'h3c, 0); cycles(LAT + 3);
    send(8'h3c, 1); send(8'h3c, 1); cycles(LAT + 3);
    send(8'h40, 1); send(8'h3c, 0); cycles(LAT + 3);
    out_ready = 1'b0;
    send(8'h55, 0); send(8'h21, 1);
    in_data = 8'h99; in_valid = 1'b1;
    cycles(LAT + 8);
    out_ready = 1'b1;
    send(8'h99, 0); send(8'h12, 0); cycles(LAT + 3);
    send(8'h3c, 0);
    reset = 1'b1; cycles(1); reset = 1'b0;
    send(8'h40, 0); send(8'h40, 0); cycles(LAT + 3);
    send(8'h7c, 0); send(8'h3c, 0); cycles(LAT + 3);
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(99) == 0);
      if (!(in_valid && !take)) begin
        in_valid = ($urandom_range(9) < 7);
        in_data = 8'($urandom);
        in_is_sub = 1'($urandom);
      end
      out_ready = ($urandom_range(9) < 6);
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycles(LAT + 20);
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
